// File: rtl/alu_result_collector.sv
// alu_result_collector
// Collects one-cycle completion strobes from four functional units (add, sub,
// mul, div), tags each result with a 2-bit op code and queues it in a
// 2-entry registered FIFO for a valid/ready consumer. Multi-strobe cycles and
// pushes into a full FIFO are dropped and flagged on sticky error outputs.
// done_count tallies every accepted result and wraps at 8 bits.

module alu_result_collector (
    input  logic        clk,
    input  logic        rst,

    input  logic        add_done,
    input  logic        sub_done,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic [15:0] add_res,
    input  logic [15:0] sub_res,
    input  logic [15:0] mul_res,
    input  logic [15:0] div_res,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_op,
    output logic [15:0] out_result,

    input  logic        err_clr,
    output logic        err_multi,
    output logic        err_ovf,
    output logic [7:0]  done_count
);

    // ------------------------------------------------------------------
    // Local types
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b10
    } state_t;

    typedef struct packed {
        op_t         op;
        logic [15:0] result;
    } entry_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [3:0] done_vec;
    logic       strobe_single;   // exactly one *_done high
    logic       strobe_multi;    // two or more *_done high
    entry_t     new_entry;       // encoded {op, result} of the single strobe

    logic       push_req;        // a valid completion this cycle
    logic       pop;             // consumer takes the head at this edge
    logic       push;            // completion actually stored
    logic       ovf_evt;         // completion dropped because FIFO is full

    state_t     state_q, state_d;
    entry_t     head_q,  head_d;   // entry presented on the output
    entry_t     tail_q,  tail_d;   // entry queued behind the head

    logic       err_multi_q, err_multi_d;
    logic       err_ovf_q,   err_ovf_d;
    logic [7:0] done_count_q, done_count_d;

    // ------------------------------------------------------------------
    // Strobe qualification and op encoding
    // ------------------------------------------------------------------

    // Classify the strobe pattern and pick the matching unit result.
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves a signal unassigned and no latch is inferred.
        done_vec      = {div_done, mul_done, sub_done, add_done};
        strobe_single = 1'b0;
        strobe_multi  = 1'b0;
        new_entry     = '{op: OP_ADD, result: 16'h0000};

        case (done_vec)
            4'b0000: begin
                // Idle cycle: results are not valid and are ignored.
            end
            4'b0001: begin
                strobe_single = 1'b1;
                new_entry     = '{op: OP_ADD, result: add_res};
            end
            4'b0010: begin
                strobe_single = 1'b1;
                new_entry     = '{op: OP_SUB, result: sub_res};
            end
            4'b0100: begin
                strobe_single = 1'b1;
                new_entry     = '{op: OP_MUL, result: mul_res};
            end
            4'b1000: begin
                strobe_single = 1'b1;
                new_entry     = '{op: OP_DIV, result: div_res};
            end
            default: begin
                strobe_multi  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Push / pop handshake
    // ------------------------------------------------------------------

    // Decide whether this edge pushes, pops, or drops on overflow.
    always_comb begin
        // Reset wins over everything, so nothing is accepted while rst is high.
        push_req = strobe_single && !rst;
        pop      = out_valid && out_ready;

        // A full FIFO only takes a new entry when the head leaves at the same edge.
        push     = push_req && ((state_q != S_TWO) || pop);
        ovf_evt  = push_req && (state_q == S_TWO) && !pop;
    end

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------

    // State register; reset empties the FIFO regardless of other inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so all
        // flops sample their inputs from the same pre-edge values.
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the EMPTY / ONE / TWO occupancy tracker.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (push) state_d = S_ONE;
            end
            S_ONE: begin
                if (push && !pop)      state_d = S_TWO;
                else if (pop && !push) state_d = S_EMPTY;
                else                   state_d = S_ONE;
            end
            S_TWO: begin
                if (pop && !push) state_d = S_ONE;
                else              state_d = S_TWO;
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // Output decode: expose the head entry, forced to zero when empty.
    always_comb begin
        out_valid  = (state_q == S_ONE) || (state_q == S_TWO);
        out_op     = 2'b00;
        out_result = 16'h0000;
        if (out_valid) begin
            out_op     = head_q.op;
            out_result = head_q.result;
        end
    end

    // ------------------------------------------------------------------
    // FIFO payload (head/tail shift structure)
    // ------------------------------------------------------------------

    // Compute the next head/tail contents from the current occupancy and handshake.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (push) head_d = new_entry;
            end
            S_ONE: begin
                if (push && pop)  head_d = new_entry;   // head leaves, new one takes its place
                else if (push)    tail_d = new_entry;   // queue behind current head
            end
            S_TWO: begin
                if (pop) begin
                    head_d = tail_q;                    // remaining entry advances
                    if (push) tail_d = new_entry;       // new entry lands behind it
                end
            end
            default: begin
            end
        endcase
    end

    // Payload storage; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        // NOTE: the data slots carry no reset: state_q marks them empty after
        // reset and the output decode masks stale contents to zero.
        head_q <= head_d;
        tail_q <= tail_d;
    end

    // ------------------------------------------------------------------
    // Sticky error flags and completion counter
    // ------------------------------------------------------------------

    // Set events beat err_clr; count only entries that were actually stored.
    always_comb begin
        err_multi_d = err_multi_q;
        if (strobe_multi && !rst) err_multi_d = 1'b1;
        else if (err_clr)         err_multi_d = 1'b0;

        err_ovf_d = err_ovf_q;
        if (ovf_evt)      err_ovf_d = 1'b1;
        else if (err_clr) err_ovf_d = 1'b0;

        done_count_d = done_count_q;
        if (push) done_count_d = done_count_q + 8'd1;   // wraps 255 -> 0
    end

    // Status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_multi_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            done_count_q <= 8'd0;
        end else begin
            err_multi_q  <= err_multi_d;
            err_ovf_q    <= err_ovf_d;
            done_count_q <= done_count_d;
        end
    end

    assign err_multi  = err_multi_q;
    assign err_ovf    = err_ovf_q;
    assign done_count = done_count_q;

endmodule
